// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform generator: output waveform mode encodings.
`timescale 1ns/1ps
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_TRI    = 2'd3
    } mode_t;

endpackage

// File: rtl/tick_div.sv
// Free-running sample-rate divider: one-cycle tick every DIV clocks, counting 0..DIV-1.
`timescale 1ns/1ps
module tick_div #(
    parameter int DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/dds_gen.sv
// Direct digital synthesis generator: phase accumulator, external sine ROM lookup and
// arithmetic sawtooth/square/triangle shapes, all with a common 3-cycle tick-to-sample latency.
`timescale 1ns/1ps
module dds_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 10,
    parameter int DIV     = 5000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PHASE_W-1:0] tune_word,
    input  logic               tune_load,
    input  logic [1:0]         mode,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_q,
    output logic               tick,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid
);

    logic               advance;
    logic [PHASE_W-1:0] phase_p0;
    logic [PHASE_W-1:0] active;
    logic [PHASE_W-1:0] pending;
    mode_t              mode_p0;
    logic               vld_p0;
    logic [DATA_W:0]    top_p1;
    mode_t              mode_p1;
    logic               vld_p1;

    // top holds the phase MSB followed by the next DATA_W bits.
    function automatic logic [DATA_W-1:0] shape(input mode_t m,
                                                input logic [DATA_W:0] top,
                                                input logic [DATA_W-1:0] q);
        logic [DATA_W-1:0] b;
        b = top[DATA_W-1:0];
        case (m)
            MODE_SINE:   return q;
            MODE_SAW:    return top[DATA_W:1];
            MODE_SQUARE: return {DATA_W{top[DATA_W]}};
            default:     return top[DATA_W] ? ~b : b;
        endcase
    endfunction

    tick_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign advance  = tick & enable;
    assign rom_addr = phase_p0[PHASE_W-1 -: ADDR_W];

    // Stage 0: accumulator; the active increment only changes on an enabled tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_p0 <= '0;
            active   <= '0;
            pending  <= '0;
            mode_p0  <= MODE_SINE;
            vld_p0   <= 1'b0;
        end else begin
            if (tune_load) begin
                pending <= tune_word;
            end
            if (advance) begin
                phase_p0 <= phase_p0 + active;
                active   <= tune_load ? tune_word : pending;
                mode_p0  <= mode_t'(mode);
            end
            vld_p0 <= advance;
        end
    end

    // Stage 1: ROM read in flight; carry phase and mode alongside it.
    always_ff @(posedge clk) begin
        top_p1  <= phase_p0[PHASE_W-1 -: DATA_W+1];
        mode_p1 <= mode_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    // Stage 2: select waveform and register the output sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            if (vld_p1) begin
                sample <= shape(mode_p1, top_p1, rom_q);
            end
            sample_valid <= vld_p1;
        end
    end

endmodule

// File: tb/tb_dds_gen.sv
// Directed bench for dds_gen with DIV=4, PHASE_W=12, ADDR_W=8, DATA_W=8 and a q=addr^0x5A ROM.
`timescale 1ns/1ps
module tb_dds_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] tune_word = '0;
    logic        tune_load = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_q = '0;
    logic        tick;
    logic [7:0]  sample;
    logic        sample_valid;

    int total = 0;
    int bad   = 0;

    dds_gen #(.PHASE_W(12), .ADDR_W(8), .DATA_W(8), .DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .tune_word    (tune_word),
        .tune_load    (tune_load),
        .mode         (mode),
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .tick         (tick),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_addr ^ 8'h5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in tick cycle T; returns in cycle T+4 (the next tick with DIV=4).
    task automatic check_pipe(input string tag, input logic exp_vld,
                              input logic [7:0] exp_addr, input logic [7:0] exp_sample);
        check({tag, "_tick"}, tick, 1'b1);
        step();
        tune_load = 1'b0;
        check({tag, "_addr"}, rom_addr, exp_addr);
        check({tag, "_v1"}, sample_valid, 1'b0);
        check({tag, "_nt1"}, tick, 1'b0);
        step();
        check({tag, "_v2"}, sample_valid, 1'b0);
        step();
        check({tag, "_v3"}, sample_valid, exp_vld);
        check({tag, "_smp"}, sample, exp_sample);
        step();
        check({tag, "_v4"}, sample_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check("rst_sample", sample, 8'h00);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_addr", rom_addr, 8'h00);
        check("rst_tick", tick, 1'b0);

        // release: this cycle is count 0
        rst = 1'b0;
        tune_word = 12'h100; tune_load = 1'b1; mode = 2'd1; enable = 1'b1;
        step();
        tune_load = 1'b0;
        check("c1_tick", tick, 1'b0);
        step();
        check("c2_tick", tick, 1'b0);
        check("c2_valid", sample_valid, 1'b0);
        step();
        check_pipe("saw0", 1'b1, 8'h00, 8'h00);
        check_pipe("saw1", 1'b1, 8'h10, 8'h10);
        check_pipe("saw2", 1'b1, 8'h20, 8'h20);

        tune_word = 12'h800; tune_load = 1'b1; mode = 2'd2;
        check_pipe("sq0", 1'b1, 8'h30, 8'h00);
        check_pipe("sq1", 1'b1, 8'hB0, 8'hFF);
        check_pipe("sq2", 1'b1, 8'h30, 8'h00);

        mode = 2'd0;
        check_pipe("sin0", 1'b1, 8'hB0, 8'hEA);
        tune_word = 12'h200; tune_load = 1'b1;
        check_pipe("sin1", 1'b1, 8'h30, 8'h6A);
        mode = 2'd1;
        check_pipe("saw3", 1'b1, 8'h50, 8'h50);

        enable = 1'b0; mode = 2'd3; tune_word = 12'h040; tune_load = 1'b1;
        check_pipe("off0", 1'b0, 8'h50, 8'h50);
        tune_word = 12'h600; tune_load = 1'b1;
        check_pipe("off1", 1'b0, 8'h50, 8'h50);
        enable = 1'b1;
        check_pipe("tri0", 1'b1, 8'h70, 8'hE0);
        check_pipe("tri1", 1'b1, 8'hD0, 8'h5F);

        // reset during T+1 of tick 14
        check("t14_tick", tick, 1'b1);
        mode = 2'd0;
        step();
        rst = 1'b1;
        step();
        check("mid_sample", sample, 8'h00);
        check("mid_valid", sample_valid, 1'b0);
        check("mid_addr", rom_addr, 8'h00);
        check("mid_tick", tick, 1'b0);
        step();
        check("mid_v3", sample_valid, 1'b0);
        rst = 1'b0;
        step();
        check("r1_tick", tick, 1'b0);
        step();
        check("r2_tick", tick, 1'b0);
        step();
        check_pipe("rst1", 1'b1, 8'h00, 8'h5A);
        check_pipe("rst2", 1'b1, 8'h00, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_gen.md
DDS_GEN -- requirements
Module: dds_gen

Interface
REQ-001 Parameter PHASE_W, default 24: phase accumulator and tuning word width.
REQ-002 Parameter ADDR_W, default 10: external waveform ROM address width; ADDR_W <= PHASE_W.
REQ-003 Parameter DATA_W, default 10: sample and ROM data width; DATA_W <= PHASE_W-1.
REQ-004 Parameter DIV, default 5000: clk cycles per sample tick; DIV >= 4.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 enable  in  1  high = accumulator advances on tick.
REQ-008 tune_word  in  PHASE_W  phase increment per tick.
REQ-009 tune_load  in  1  one-cycle strobe; captures tune_word.
REQ-010 mode  in  2  0 sine (ROM), 1 sawtooth, 2 square, 3 triangle.
REQ-011 rom_addr  out  ADDR_W  address to external synchronous ROM (1-cycle read latency).
REQ-012 rom_q  in  DATA_W  ROM read data.
REQ-013 tick  out  1  one-cycle pulse every DIV cycles.
REQ-014 sample  out  DATA_W  registered output sample, unsigned offset-binary.
REQ-015 sample_valid  out  1  one-cycle pulse; sample updated; drives DAC/PWM load.

Function
REQ-016 Divider counts 0..DIV-1 then wraps to 0; tick high exactly while count == DIV-1, regardless of enable.
REQ-017 tune_load SHALL write tune_word into a pending register; the active increment SHALL update only on tick (glitch-free retune).
REQ-018 On a tick with enable high: phase <= (phase + active) mod 2^PHASE_W using the old active; active <= tune_load ? tune_word : pending; mode latched into mode_r.
REQ-019 tune_load coincident with tick: new tune_word becomes active at that tick and is first added on the following tick.
REQ-020 On tick with enable low: phase, mode_r, active hold; pending still loads; no sample_valid generated.
REQ-021 rom_addr SHALL equal phase[PHASE_W-1 -: ADDR_W] continuously from the phase register.
REQ-022 Let T be the tick cycle: phase new at T+1, rom_q valid at T+2, sample registered at end of T+2, sample_valid high in cycle T+3 only.
REQ-023 Modes 1-3 SHALL be pipelined to identical 3-cycle latency as mode 0.
REQ-024 Sawtooth: sample = phase[PHASE_W-1 -: DATA_W].
REQ-025 Square: sample = all-ones when phase MSB = 1, else 0.
REQ-026 Triangle: b = phase[PHASE_W-2 -: DATA_W]; sample = MSB ? ~b : b.
REQ-027 Mode changes mid-period take effect only at the next enabled tick; no mixed-mode sample.
REQ-028 sample holds its last value between sample_valid pulses and while enable low.
REQ-029 Phase wrap-around SHALL be silent modulo arithmetic; no overflow flag.

Reset
REQ-030 rst high at a clock edge SHALL clear count, phase, pending, active, mode_r, pipeline valids, sample and sample_valid to 0; tick low.
REQ-031 rst mid-pipeline SHALL cancel any in-flight sample; no sample_valid until 3 cycles after the first enabled tick after reset.
REQ-032 First tick after release occurs DIV cycles after rst deasserts.

Structure
REQ-033 Mode encodings (MODE_SINE..MODE_TRI) SHALL live in the shared package dds_pkg.
REQ-034 The divider SHALL be a sub-module tick_div (parameter DIV, ports clk, rst, tick).
REQ-035 The ROM remains external; dds_gen contains no memory.

Verification (DIV=4, PHASE_W=12, ADDR_W=8, DATA_W=8)
REQ-036 Reset release -> tick at cycles 3,7,11 after release; sample=0, sample_valid=0 until first enabled tick + 3.
REQ-037 tune_load 0x100 before first tick, mode 1, enable 1 -> active at tick 1; sawtooth samples 0x10,0x20,... one per 4 cycles, each sample_valid 3 cycles after its tick.
REQ-038 tune 0x800, mode 2 -> square alternates 0xFF,0x00 per tick; phase wraps 0x800->0x000.
REQ-039 Mode 0, ROM model q=addr^0x5A -> sample equals model of rom_addr presented one cycle earlier; latency matches mode 1.
REQ-040 tune_load 0x200 coincident with tick -> increment 0x200 first added on next tick; enable low for 2 ticks -> phase, sample frozen, no sample_valid.
REQ-041 rst asserted in T+1 of a tick -> no sample_valid in T+3; all outputs 0 next cycle.
